// File: rtl/char_buf_pkg.sv
// Shared definitions for the character buffer controller.
// Optional form feed clear is enabled by CHAR_BUF_FORMFEED_EN.
package char_buf_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SCROLL_CP  = 2'd1;
    localparam logic [1:0] SCROLL_CLR = 2'd2;
    localparam logic [1:0] CLEAR      = 2'd3;

    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;
    localparam logic [7:0] BS   = 8'h08;
    localparam logic [7:0] DEL  = 8'h7F;
    localparam logic [7:0] TAB  = 8'h09;
    localparam logic [7:0] HOME = 8'h01;
    localparam logic [7:0] FF   = 8'h0C;

    localparam logic [6:0] FILL_CHAR = 7'h20;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/char_buf_if.sv
// Byte stream handshake into the character buffer controller.
// Master drives valid/data, slave answers with ready.
interface char_buf_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/char_buf_fill_engine.sv
// Scroll/clear address sequencer; owns the controller FSM state.
// CLEAR sequencing exists only when CHAR_BUF_FORMFEED_EN is defined.
module char_buf_fill_engine
    import char_buf_pkg::*;
#(
    parameter int COLS   = 160,
    parameter int ROWS   = 90,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_scroll,
`ifdef CHAR_BUF_FORMFEED_EN
    input  logic              go_clear,
`endif
    input  logic [6:0]        mem_rdata,
    output state_t            state,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data
);

    localparam int CP_LEN = COLS * (ROWS - 1);
`ifdef CHAR_BUF_FORMFEED_EN
    localparam int CELLS  = COLS * ROWS;
`endif

    logic [ADDR_W-1:0] cnt;
    logic              last;

    // final cycle of the current phase
    always_comb begin
        last = 1'b0;
        unique case (state)
            SCROLL_CP:  last = (cnt == ADDR_W'(CP_LEN));
            SCROLL_CLR: last = (cnt == ADDR_W'(COLS - 1));
`ifdef CHAR_BUF_FORMFEED_EN
            CLEAR:      last = (cnt == ADDR_W'(CELLS - 1));
`endif
            default:    last = 1'b0;
        endcase
    end

    // phase state and cell counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (go_scroll)
                        state <= SCROLL_CP;
`ifdef CHAR_BUF_FORMFEED_EN
                    else if (go_clear)
                        state <= CLEAR;
`endif
                end
                SCROLL_CP: begin
                    if (last) begin
                        state <= SCROLL_CLR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                SCROLL_CLR: begin
                    if (last)
                        state <= IDLE;
                    else
                        cnt <= cnt + ADDR_W'(1);
                end
`ifdef CHAR_BUF_FORMFEED_EN
                CLEAR: begin
                    if (last)
                        state <= IDLE;
                    else
                        cnt <= cnt + ADDR_W'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // copy reads run one cell ahead of the writes they feed
    always_comb begin
        rd_addr = cnt + ADDR_W'(COLS);
        wr_en   = 1'b0;
        wr_addr = cnt;
        wr_data = FILL_CHAR;
        unique case (state)
            SCROLL_CP: begin
                wr_en   = (cnt != '0);
                wr_addr = cnt - ADDR_W'(1);
                wr_data = mem_rdata;
            end
            SCROLL_CLR: begin
                wr_en   = 1'b1;
                wr_addr = cnt + ADDR_W'(CP_LEN);
            end
`ifdef CHAR_BUF_FORMFEED_EN
            CLEAR: wr_en = 1'b1;
`endif
            default: wr_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/char_buf_ctrl.sv
// Character buffer controller: cursor logic and RAM port arbitration.
// Define CHAR_BUF_FORMFEED_EN to make 0x0C clear the whole screen.
module char_buf_ctrl
    import char_buf_pkg::*;
#(
    parameter int COLS   = 160,
    parameter int ROWS   = 90,
    parameter int ADDR_W = 14,
    parameter int TAB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    char_buf_if.slave         rx,
    input  logic [ADDR_W-1:0] scan_raddr,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [6:0]        mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [6:0]        mem_wdata,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int CW    = ADDR_W + 1;

    state_t            state;
    logic              accept;
    logic              wrap;
    logic [ADDR_W:0]   cur_ext;
    logic [ADDR_W:0]   nxt;
    logic              char_we;
    logic [ADDR_W-1:0] char_waddr;
    logic [6:0]        char_wdata;
    logic [ADDR_W-1:0] eng_raddr;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_waddr;
    logic [6:0]        eng_wdata;
`ifdef CHAR_BUF_FORMFEED_EN
    logic              is_ff;
`endif

    assign rx.in_ready = (state == IDLE) && !rst;
    assign accept      = rx.in_valid && rx.in_ready;
    assign busy        = (state != IDLE);
    assign cur_ext     = {1'b0, cursor_addr};
    assign mem_raddr   = (state == SCROLL_CP) ? eng_raddr : scan_raddr;
    assign wrap        = (nxt >= CW'(CELLS));

    // decode the byte into a cursor move and an optional cell write
    always_comb begin
        nxt        = cur_ext;
        char_we    = 1'b0;
        char_waddr = cursor_addr;
        char_wdata = rx.in_data[6:0];
`ifdef CHAR_BUF_FORMFEED_EN
        is_ff      = 1'b0;
`endif
        unique case (1'b1)
            is_printable(rx.in_data): begin
                nxt     = cur_ext + CW'(1);
                char_we = 1'b1;
            end
            (rx.in_data == CR):
                nxt = (cur_ext / CW'(COLS)) * CW'(COLS);
            (rx.in_data == HOME):
                nxt = '0;
            (rx.in_data == LF):
                nxt = cur_ext + CW'(COLS);
            (rx.in_data == TAB):
                nxt = (cur_ext & ~CW'(TAB_W - 1)) + CW'(TAB_W);
            ((rx.in_data == BS || rx.in_data == DEL)
             && cursor_addr != '0): begin
                nxt        = cur_ext - CW'(1);
                char_we    = 1'b1;
                char_waddr = cursor_addr - ADDR_W'(1);
                char_wdata = FILL_CHAR;
            end
`ifdef CHAR_BUF_FORMFEED_EN
            (rx.in_data == FF): begin
                nxt   = '0;
                is_ff = 1'b1;
            end
`endif
            default: nxt = cur_ext;
        endcase
    end

    // cursor update; wrapping past the last cell pulls back one row
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cursor_addr <= '0;
        else if (accept)
            cursor_addr <= wrap ? ADDR_W'(nxt - CW'(COLS))
                                : nxt[ADDR_W-1:0];
    end

    // registered RAM write port, fill engine has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else if (eng_we) begin
            mem_we    <= 1'b1;
            mem_waddr <= eng_waddr;
            mem_wdata <= eng_wdata;
        end else begin
            mem_we    <= accept && char_we;
            mem_waddr <= char_waddr;
            mem_wdata <= char_wdata;
        end
    end

    char_buf_fill_engine #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .go_scroll (accept && wrap),
`ifdef CHAR_BUF_FORMFEED_EN
        .go_clear  (accept && is_ff),
`endif
        .mem_rdata (mem_rdata),
        .state     (state),
        .rd_addr   (eng_raddr),
        .wr_en     (eng_we),
        .wr_addr   (eng_waddr),
        .wr_data   (eng_wdata)
    );

endmodule

// File: tb/tb_char_buf_ctrl.sv
// Self-checking bench for char_buf_ctrl (4x3 screen, tab 4).
// Random bytes are compared against an array-based screen model.
module tb_char_buf_ctrl;

    localparam int COLS   = 4;
    localparam int ROWS   = 3;
    localparam int ADDR_W = 8;
    localparam int TAB_W  = 4;
    localparam int CELLS  = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] scan_raddr = '0;
    logic [ADDR_W-1:0] mem_raddr;
    logic [6:0]        mem_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [6:0]        mem_wdata;
    logic [ADDR_W-1:0] cursor_addr;
    logic              busy;

    char_buf_if rx_if();

    char_buf_ctrl #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .TAB_W  (TAB_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx_if),
        .scan_raddr  (scan_raddr),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .cursor_addr (cursor_addr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // character RAM with 1-cycle read latency, preloadable by the bench
    logic [6:0] ram  [0:255];
    logic [6:0] seed [0:255];
    logic       load = 1'b0;

    always @(posedge clk) begin
        mem_rdata <= ram[mem_raddr];
        if (load) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= seed[i];
        end else if (mem_we) begin
            ram[mem_waddr] <= mem_wdata;
        end
    end

    int checks   = 0;
    int failures = 0;

    logic [6:0] mram [0:CELLS-1];
    int         mcur;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // screen model: plain arithmetic on a cell array
    task automatic model_byte(input logic [7:0] b);
        int n;
        n = mcur;
        if (b >= 8'h20 && b <= 8'h7E) begin
            mram[mcur] = b[6:0];
            n = mcur + 1;
        end else if (b == 8'h0D) begin
            n = (mcur / COLS) * COLS;
        end else if (b == 8'h01) begin
            n = 0;
        end else if (b == 8'h0A) begin
            n = mcur + COLS;
        end else if (b == 8'h09) begin
            n = (mcur / TAB_W + 1) * TAB_W;
        end else if ((b == 8'h08 || b == 8'h7F) && mcur > 0) begin
            n = mcur - 1;
            mram[n] = 7'h20;
`ifdef CHAR_BUF_FORMFEED_EN
        end else if (b == 8'h0C) begin
            for (int i = 0; i < CELLS; i++)
                mram[i] = 7'h20;
            n = 0;
`endif
        end
        if (n >= CELLS) begin
            n = n - COLS;
            for (int i = 0; i < CELLS - COLS; i++)
                mram[i] = mram[i + COLS];
            for (int i = CELLS - COLS; i < CELLS; i++)
                mram[i] = 7'h20;
        end
        mcur = n;
    endtask

    function automatic logic [127:0] ram_screen();
        logic [127:0] v = '0;
        for (int i = 0; i < CELLS; i++)
            v[i*7 +: 7] = ram[i];
        return v;
    endfunction

    function automatic logic [127:0] model_screen();
        logic [127:0] v = '0;
        for (int i = 0; i < CELLS; i++)
            v[i*7 +: 7] = mram[i];
        return v;
    endfunction

    task automatic do_reset();
        rx_if.in_valid = 1'b0;
        rx_if.in_data  = '0;
        rst  = 1'b1;
        load = 1'b1;
        for (int i = 0; i < 256; i++)
            seed[i] = 7'($urandom);
        for (int i = 0; i < CELLS; i++)
            mram[i] = seed[i];
        mcur = 0;
        tick();
        load = 1'b0;
        check("rst_cursor", 128'(cursor_addr), 0);
        check("rst_busy", 128'(busy), 0);
        check("rst_we", 128'(mem_we), 0);
        check("rst_ready", 128'(rx_if.in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 128'(rx_if.in_ready), 1);
    endtask

    // returns one cycle after the accepting edge
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_if.in_valid = 1'b1;
        rx_if.in_data  = b;
        while (!rx_if.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!rx_if.in_ready)
            check("ready_timeout", 128'(rx_if.in_ready), 1);
        tick();
        rx_if.in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic settle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_timeout", 128'(busy), 0);
        tick();
        tick();
    endtask

    task automatic compare(input string tag);
        check({tag, "_cursor"}, 128'(cursor_addr), 128'(mcur));
        check({tag, "_screen"}, ram_screen(), model_screen());
    endtask

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(8'h20, 8'h7E));
    endfunction

    initial begin
        logic [7:0] ctrl [0:6];
        logic [7:0] b;
        logic       seen_ready;
        logic       seen_we;
        int         n;
        int         r;

        ctrl[0] = 8'h0D; ctrl[1] = 8'h0A; ctrl[2] = 8'h08;
        ctrl[3] = 8'h7F; ctrl[4] = 8'h09; ctrl[5] = 8'h01;
        ctrl[6] = 8'h0C;
        rx_if.in_valid = 1'b0;
        rx_if.in_data  = '0;

        // single printable write
        do_reset();
        send(8'h41);
        check("a_we", 128'(mem_we), 1);
        check("a_waddr", 128'(mem_waddr), 0);
        check("a_wdata", 128'(mem_wdata), 128'h41);
        check("a_cursor", 128'(cursor_addr), 1);
        settle();
        compare("a");

        // scroll timing and copy read sequence
        do_reset();
        scan_raddr = 8'd7;
        #1;
        check("idle_raddr", 128'(mem_raddr), 7);
        for (int i = 0; i < 11; i++)
            send(rand_print());
        scan_raddr = 8'($urandom_range(0, 200));
        send(rand_print());
        n = 0;
        seen_ready = 1'b0;
        while (busy && n < 100) begin
            if (n < COLS * (ROWS - 1))
                check("cp_raddr", 128'(mem_raddr), 128'(COLS + n));
            seen_ready = seen_ready | rx_if.in_ready;
            tick();
            n++;
        end
        check("scroll_cycles", 128'(n), 13);
        check("scroll_ready", 128'(seen_ready), 0);
        settle();
        check("scroll_cursor", 128'(cursor_addr), 8);
        compare("scroll");

        // carriage return, home, backspace at origin
        do_reset();
        for (int i = 0; i < 6; i++)
            send(rand_print());
        settle();
        check("cr_pre", 128'(cursor_addr), 6);
        send(8'h0D);
        check("cr_we", 128'(mem_we), 0);
        check("cr_cursor", 128'(cursor_addr), 4);
        send(8'h01);
        check("home_cursor", 128'(cursor_addr), 0);
        send(8'h08);
        check("bs0_we", 128'(mem_we), 0);
        check("bs0_cursor", 128'(cursor_addr), 0);
        settle();
        compare("ctl");

        // tab and line feed with scroll
        do_reset();
        send(rand_print());
        send(8'h09);
        check("tab_cursor", 128'(cursor_addr), 4);
        for (int i = 0; i < 5; i++)
            send(rand_print());
        check("lf_pre", 128'(cursor_addr), 9);
        send(8'h0A);
        check("lf_busy", 128'(busy), 1);
        settle();
        check("lf_cursor", 128'(cursor_addr), 9);
        compare("lf");

        // reset in the 5th cycle of a scroll
        do_reset();
        for (int i = 0; i < 12; i++)
            send(rand_print());
        repeat (4) tick();
        check("abort_pre_busy", 128'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 0);
        check("abort_cursor", 128'(cursor_addr), 0);
        seen_we = mem_we;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen_we = seen_we | mem_we;
            tick();
        end
        check("abort_no_we", 128'(seen_we), 0);

        // random byte stream against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)
                b = rand_print();
            else if (r < 8)
                b = ctrl[$urandom_range(0, 6)];
            else
                b = 8'($urandom);
            scan_raddr = 8'($urandom);
            send(b);
            settle();
            compare("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_buf_ctrl.md
CHAR_BUF_CTRL -- requirements
Module: char_buf_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 160, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 90, meaning text rows.
REQ-003 SHALL have parameter ADDR_W, default 14, meaning character RAM address width.
REQ-004 SHALL have parameter TAB_W, default 4, meaning tab stop spacing, power of two.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: received byte valid.
REQ-009 SHALL have port in_data, input, 8 bits: received byte.
REQ-010 SHALL have port in_ready, output, 1 bit: byte accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port scan_raddr, input, ADDR_W bits: video scan read address.
REQ-012 SHALL have port mem_raddr, output, ADDR_W bits: arbitrated RAM read address.
REQ-013 SHALL have port mem_rdata, input, 7 bits: RAM read data, 1-cycle latency.
REQ-014 SHALL have ports mem_we (output, 1 bit), mem_waddr (output, ADDR_W bits) and mem_wdata (output, 7 bits): RAM write port.
REQ-015 SHALL have port cursor_addr, output, ADDR_W bits: current cursor cell.
REQ-016 SHALL have port busy, output, 1 bit: scroll or clear in progress; video blanks text while it is high.

Function
REQ-017 SHALL implement FSM states IDLE, SCROLL_CP, SCROLL_CLR and CLEAR; in_ready SHALL be 1 only in IDLE.
REQ-018 SHALL register all write-port outputs, so a write occurs in the cycle after acceptance.
REQ-019 On a printable byte (0x20..0x7E), SHALL write in_data[6:0] at cursor_addr and set cursor to cursor+1.
REQ-020 On 0x0D, SHALL set cursor to (cursor/COLS)*COLS; 0x01 SHALL set cursor to 0; neither SHALL write.
REQ-021 On 0x0A, SHALL set cursor to cursor+COLS.
REQ-022 On 0x09, SHALL set cursor to the next multiple of TAB_W, strictly greater than the current cursor.
REQ-023 On 0x08 or 0x7F with cursor>0, SHALL set cursor to cursor-1 and write 0x20 there; at cursor 0, SHALL do nothing.
REQ-024 Other bytes, and any byte with bit 7 set, SHALL be consumed and ignored.
REQ-025 If a new cursor value is >= COLS*ROWS, SHALL set cursor to that value minus COLS and enter SCROLL_CP.
REQ-026 SCROLL_CP SHALL be pipelined: for each dst 0..COLS*(ROWS-1)-1, read dst+COLS at cycle t and write mem_rdata to dst at cycle t+1; total COLS*(ROWS-1)+1 cycles.
REQ-027 SCROLL_CLR SHALL write 0x20 to the last row, one cell per cycle (COLS cycles), then return to IDLE.
REQ-028 mem_raddr SHALL equal scan_raddr in IDLE and CLEAR, and equal the copy source address in SCROLL_CP.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 Arithmetic on the cursor SHALL be performed at ADDR_W+1 bits before the bound comparison, so no silent wrap occurs.

Reset
REQ-031 On rst, SHALL set state IDLE, cursor_addr 0, mem_we 0, busy 0, and hold in_ready 0 until rst is released.
REQ-032 rst mid-scroll or mid-clear SHALL abort the operation immediately, SHALL perform no further writes, and SHALL leave RAM contents undefined/partial.

Configuration
REQ-033 With CHAR_BUF_FORMFEED_EN defined, 0x0C SHALL enter CLEAR, write 0x20 to all COLS*ROWS cells (one per cycle), set cursor 0, then return to IDLE.
REQ-034 Without CHAR_BUF_FORMFEED_EN, 0x0C SHALL be ignored per REQ-024, and no CLEAR state logic SHALL be synthesized.

Structure
REQ-035 Package char_buf_pkg SHALL hold the FSM state encoding, the control-character constants (CR, LF, BS, DEL, TAB, HOME, FF) and FILL_CHAR=0x20.
REQ-036 The scroll/clear address sequencer SHALL be a single sub-module, char_buf_fill_engine; the top of the block holds the cursor logic and the arbitration.

Verification (COLS=4, ROWS=3, TAB_W=4)
REQ-037 Reset, then send 0x41 -> next cycle: mem_we=1, waddr=0, wdata=0x41; cursor_addr=1.
REQ-038 Send 12 printable bytes -> after the 12th: busy=1 and in_ready=0 for 13 cycles; cells 0..7 = old 4..11; cells 8..11 = 0x20; cursor=8.
REQ-039 Cursor 6, send 0x0D -> cursor 4, no write; cursor 0, send 0x08 -> no write, cursor 0.
REQ-040 Cursor 1, send 0x09 -> cursor 4; cursor 9, send 0x0A -> scroll, cursor 9.
REQ-041 Assert rst in the 5th cycle of a scroll -> busy=0 and cursor=0 in the same cycle; mem_we stays 0 afterwards.
REQ-042 In IDLE, scan_raddr=7 -> mem_raddr=7; during SCROLL_CP, mem_raddr follows 4,5,6,...,11 regardless of scan_raddr.
